// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between instruction fetch
//   (IF) and data memory (DM). In IDLE the grant is combinational, so the
//   access issues in the same cycle the request is seen. A read returns after
//   MEM_LATENCY cycles. A write is acknowledged one cycle after issue.
//
//   Optional feature: define ARB_RR_EN for round-robin arbitration. When
//   both requesters are pending, the one not granted last wins. Without it,
//   DM always wins over IF.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   IfReq_i/IfAddr_i              fetch request, held until IfValid_o
//   IfRdata_o/IfValid_o           fetch data and one-cycle completion pulse
//   DmReq_i/DmWe_i/DmAddr_i       data request, held until DmValid_o
//   DmWdata_i/DmBe_i              write data and byte enables
//   DmRdata_o/DmValid_o           load data and one-cycle completion pulse
//   Mem*_o / MemRdata_i           memory issue side; read data is valid
//                                 exactly MEM_LATENCY cycles after issue
//   StallF_o/StallM_o             stall requests to the hazard unit
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IfReq_i,
  input  logic [ADDRESS_WIDTH-1:0]  IfAddr_i,
  output logic [DATA_WIDTH-1:0]     IfRdata_o,
  output logic                      IfValid_o,
  input  logic                      DmReq_i,
  input  logic                      DmWe_i,
  input  logic [ADDRESS_WIDTH-1:0]  DmAddr_i,
  input  logic [DATA_WIDTH-1:0]     DmWdata_i,
  input  logic [DATA_WIDTH/8-1:0]   DmBe_i,
  output logic [DATA_WIDTH-1:0]     DmRdata_o,
  output logic                      DmValid_o,
  output logic                      MemReq_o,
  output logic                      MemWe_o,
  output logic [ADDRESS_WIDTH-1:0]  MemAddr_o,
  output logic [DATA_WIDTH-1:0]     MemWdata_o,
  output logic [DATA_WIDTH/8-1:0]   MemBe_o,
  input  logic [DATA_WIDTH-1:0]     MemRdata_i,
  output logic                      StallF_o,
  output logic                      StallM_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

  state_t        state;
  logic          ownerDm;   // 0 = IF owns the access in flight, 1 = DM
  logic [CW-1:0] cnt;
`ifdef ARB_RR_EN
  logic          lastDm;    // last issue went to DM
`endif

  logic grantDm, grantIf, issue, done;

  always_comb begin
`ifdef ARB_RR_EN
    grantDm = DmReq_i & (~IfReq_i | ~lastDm);
`else
    grantDm = DmReq_i;
`endif
    grantIf = IfReq_i & ~grantDm;
    // rst gates the issue path so that Mem* outputs are 0 while reset is asserted
    issue   = rst && (state == IDLE) && (grantDm || grantIf);
    done    = (state == RD_WAIT) && (cnt == CW'(MEM_LATENCY));
  end

  // Memory issue side, steered from the winning requester
  always_comb begin
    MemReq_o   = issue;
    MemWe_o    = 1'b0;
    MemAddr_o  = '0;
    MemWdata_o = '0;
    MemBe_o    = '0;
    if (issue) begin
      if (grantDm) begin
        MemWe_o    = DmWe_i;
        MemAddr_o  = DmAddr_i;
        MemWdata_o = DmWdata_i;
        MemBe_o    = DmBe_i;
      end else begin
        MemAddr_o  = IfAddr_i;
        MemBe_o    = {BW{1'b1}};
      end
    end
  end

  // Completion: read data passes straight through in the cnt==MEM_LATENCY cycle
  always_comb begin
    IfValid_o = done & ~ownerDm;
    DmValid_o = (done & ownerDm) | (state == WR_ACK);
    IfRdata_o = (done & ~ownerDm) ? MemRdata_i : '0;
    DmRdata_o = (done &  ownerDm) ? MemRdata_i : '0;
    StallF_o  = IfReq_i & ~IfValid_o;
    StallM_o  = DmReq_i & ~DmValid_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ownerDm <= 1'b0;
`ifdef ARB_RR_EN
      lastDm  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (issue) begin
          ownerDm <= grantDm;
`ifdef ARB_RR_EN
          lastDm  <= grantDm;
`endif
          if (grantDm && DmWe_i) begin
            state <= WR_ACK;
          end else begin
            state <= RD_WAIT;
            cnt   <= CW'(1);
          end
        end
        RD_WAIT: if (done) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt   <= cnt + CW'(1);
        end
        WR_ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
